// File: rtl/lif_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lif_scheduler                                                              |
// | Time-multiplexed leaky integrate-and-fire controller with AER spike output.|
// | Optional macro: LIF_SCHED_REFRACTORY_EN (one-timestep refractory period).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lif_scheduler #(
  parameter int N_NEURONS = 8,
  parameter int IDX_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [N_NEURONS-1:0] syn,
  input  logic [7:0]           weight,
  input  logic [7:0]           tau,
  input  logic [7:0]           threshold,
  input  logic                 spike_ready,
  output logic                 spike_valid,
  output logic [IDX_W-1:0]     spike_id,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun,
  input  logic [IDX_W-1:0]     v_addr,
  output logic [7:0]           v_data
);

  localparam logic [1:0]       c_idle     = 2'd0;
  localparam logic [1:0]       c_update   = 2'd1;
  localparam logic [1:0]       c_done     = 2'd2;
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N_NEURONS - 1);

  logic [1:0]           r_state;
  logic [1:0]           w_state_next;
  logic [IDX_W-1:0]     r_idx;
  logic [7:0]           r_v [N_NEURONS];
  logic [N_NEURONS-1:0] r_syn;
  logic [7:0]           r_weight;
  logic [7:0]           r_tau;
  logic [7:0]           r_thr;
  logic                 r_spike_valid;
  logic [IDX_W-1:0]     r_spike_id;
  logic                 r_overrun;

  logic                 w_stall;
  logic                 w_process;
  logic                 w_last;
  logic                 w_integ;
  logic                 w_fire;
  logic [7:0]           w_v_cur;
  logic [7:0]           w_leak;
  logic [8:0]           w_sum;
  logic [7:0]           w_new;

  // A pending event blocks the datapath unless it is transferred this cycle.
  assign w_stall   = r_spike_valid && !spike_ready;
  assign w_process = (r_state == c_update) && !w_stall;
  assign w_last    = (r_idx == c_last_idx);
  assign w_v_cur   = r_v[r_idx];

`ifdef LIF_SCHED_REFRACTORY_EN
  logic [N_NEURONS-1:0] r_ref;

  assign w_integ = r_syn[r_idx] && !r_ref[r_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ref <= '0;
    end else if (w_process) begin
      r_ref[r_idx] <= w_fire;
    end
  end
`else
  assign w_integ = r_syn[r_idx];
`endif

  assign w_leak = (w_v_cur > r_tau) ? (w_v_cur - r_tau) : 8'd0;
  assign w_sum  = {1'b0, w_leak} + {1'b0, (w_integ ? r_weight : 8'd0)};
  assign w_new  = w_sum[8] ? 8'hFF : w_sum[7:0];
  assign w_fire = (w_new >= r_thr);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic; the DONE state makes a tick coincident with done ignorable.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle:   if (tick) w_state_next = c_update;
      c_update: if (w_process && w_last) w_state_next = c_done;
      c_done:   w_state_next = c_idle;
      default:  w_state_next = c_idle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      c_update: busy = 1'b1;
      c_done:   done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx         <= '0;
      r_syn         <= '0;
      r_weight      <= '0;
      r_tau         <= '0;
      r_thr         <= '0;
      r_spike_valid <= 1'b0;
      r_spike_id    <= '0;
      r_overrun     <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        r_v[i] <= '0;
      end
    end else begin
      if (r_state == c_idle && tick) begin
        r_idx    <= '0;
        r_syn    <= syn;
        r_weight <= weight;
        r_tau    <= tau;
        r_thr    <= threshold;
      end
      if (r_state == c_update && tick) begin
        r_overrun <= 1'b1;
      end
      if (w_process) begin
        r_v[r_idx] <= w_fire ? 8'd0 : w_new;
        r_idx      <= w_last ? '0 : r_idx + 1'b1;
      end
      if (w_process && w_fire) begin
        r_spike_valid <= 1'b1;
        r_spike_id    <= r_idx;
      end else if (r_spike_valid && spike_ready) begin
        r_spike_valid <= 1'b0;
      end
    end
  end

  assign spike_valid = r_spike_valid;
  assign spike_id    = r_spike_id;
  assign overrun     = r_overrun;
  assign v_data      = (v_addr <= c_last_idx) ? r_v[v_addr] : 8'd0;

endmodule
`default_nettype wire

// File: tb/tb_lif_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lif_scheduler                                                           |
// | Directed bench with a spike-id scoreboard and a behavioural neuron model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_lif_scheduler;

  localparam int N_NEURONS = 4;
  localparam int IDX_W     = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 tick = 1'b0;
  logic [N_NEURONS-1:0] syn = '0;
  logic [7:0]           weight = '0;
  logic [7:0]           tau = '0;
  logic [7:0]           threshold = '0;
  logic                 spike_ready = 1'b1;
  logic                 spike_valid;
  logic [IDX_W-1:0]     spike_id;
  logic                 busy;
  logic                 done;
  logic                 overrun;
  logic [IDX_W-1:0]     v_addr = '0;
  logic [7:0]           v_data;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  int exp_q[$];
  int m_v [N_NEURONS];
  bit m_ref [N_NEURONS];

  lif_scheduler #(.N_NEURONS(N_NEURONS), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .tick(tick), .syn(syn), .weight(weight), .tau(tau),
    .threshold(threshold), .spike_ready(spike_ready), .spike_valid(spike_valid),
    .spike_id(spike_id), .busy(busy), .done(done), .overrun(overrun),
    .v_addr(v_addr), .v_data(v_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Every accepted event must match the next expected neuron index.
  always @(negedge clk) begin
    if (!rst && spike_valid && spike_ready) begin
      hs_count++;
      chk("spike_id", 32'(spike_id), (exp_q.size() > 0) ? exp_q.pop_front() : -1);
    end
  end

  task automatic model_reset();
    for (int i = 0; i < N_NEURONS; i++) begin
      m_v[i]   = 0;
      m_ref[i] = 1'b0;
    end
    exp_q.delete();
  endtask

  task automatic model_sweep();
    int l;
    int n;
    bit integ;
    for (int i = 0; i < N_NEURONS; i++) begin
      l = (m_v[i] > int'(tau)) ? m_v[i] - int'(tau) : 0;
      integ = syn[i] && !m_ref[i];
      n = l + (integ ? int'(weight) : 0);
      if (n > 255) n = 255;
      if (n >= int'(threshold)) begin
        exp_q.push_back(i);
        m_v[i] = 0;
`ifdef LIF_SCHED_REFRACTORY_EN
        m_ref[i] = 1'b1;
`endif
      end else begin
        m_v[i]   = n;
        m_ref[i] = 1'b0;
      end
    end
  endtask

  task automatic check_v(input string tag);
    for (int i = 0; i < N_NEURONS; i++) begin
      v_addr = IDX_W'(i);
      #1;
      chk($sformatf("%s_v%0d", tag, i), 32'(v_data), m_v[i]);
    end
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!done && cnt < 200) begin
      step();
      cnt++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_reset();
  endtask

  // Unstalled sweep: checks busy, done latency, done width and final membranes.
  task automatic run_sweep(input string tag);
    int cnt;
    model_sweep();
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 1);
    wait_done(cnt);
    chk({tag, "_done_lat"}, cnt, N_NEURONS);
    chk({tag, "_busy_at_done"}, 32'(busy), 0);
    step();
    chk({tag, "_done_pulse"}, 32'(done), 0);
    check_v(tag);
  endtask

  initial begin
    int cnt;
    int hs_before;
    int pre [N_NEURONS];

    do_reset();
    chk("rst_valid", 32'(spike_valid), 0);
    chk("rst_id", 32'(spike_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_overrun", 32'(overrun), 0);
    check_v("rst");

    weight = 8'd100; tau = 8'd10; threshold = 8'd200; syn = 4'b1111; spike_ready = 1'b1;
    run_sweep("tick1");
    run_sweep("tick2");
    hs_before = hs_count;
    run_sweep("tick3");
    chk("tick3_hs", hs_count - hs_before, 4);
    run_sweep("tick4");

    do_reset();
    weight = 8'd255; tau = 8'd0; threshold = 8'd255; syn = 4'b0001;
    hs_before = hs_count;
    run_sweep("sat");
    chk("sat_hs", hs_count - hs_before, 1);
    weight = 8'd30; syn = 4'b0010;
    run_sweep("v30");
    tau = 8'd50; syn = 4'b0000;
    run_sweep("floor");

    weight = 8'd0; tau = 8'd0; threshold = 8'd0;
    hs_before = hs_count;
    run_sweep("thr0");
    chk("thr0_hs", hs_count - hs_before, 4);

    weight = 8'd1; threshold = 8'd255; syn = 4'b1111;
    model_sweep();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("ovr_set", 32'(overrun), 1);
    wait_done(cnt);
    chk("ovr_done", 32'(done), 1);
    step();
    step();
    chk("ovr_sticky", 32'(overrun), 1);
    chk("ovr_idle", 32'(busy), 0);
    check_v("ovr");

    do_reset();
    weight = 8'd100; tau = 8'd10; threshold = 8'd200; syn = 4'b1111;
    run_sweep("bp_pre1");
    run_sweep("bp_pre2");
    for (int i = 0; i < N_NEURONS; i++) pre[i] = m_v[i];
    hs_before = hs_count;
    model_sweep();
    spike_ready = 1'b0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    for (int k = 0; k < 6; k++) begin
      chk("bp_valid", 32'(spike_valid), 1);
      chk("bp_id", 32'(spike_id), 0);
      chk("bp_busy", 32'(busy), 1);
      for (int i = 1; i < N_NEURONS; i++) begin
        v_addr = IDX_W'(i);
        #1;
        chk("bp_hold_v", 32'(v_data), pre[i]);
      end
      step();
    end
    spike_ready = 1'b1;
    wait_done(cnt);
    chk("bp_done_lat", cnt, N_NEURONS - 1);
    step();
    chk("bp_hs", hs_count - hs_before, 4);
    check_v("bp");

    spike_ready = 1'b0; threshold = 8'd0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("mid_pending", 32'(spike_valid), 1);
    chk("mid_overrun", 32'(overrun), 1);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 32'(spike_valid), 0);
    chk("mid_rst_id", 32'(spike_id), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_overrun", 32'(overrun), 0);
    rst = 1'b0;
    model_reset();
    check_v("mid_rst");
    step();
    chk("mid_idle_busy", 32'(busy), 0);
    spike_ready = 1'b1;
    step();
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
